// File: rtl/stream_sched_if.sv
// Bundles the configuration, per-channel data, output word and memory-controller
// stream signals of stream_sched into a single port.
interface stream_sched_if #(
    parameter int NUM_CHANNELS    = 4,
    parameter int MAIN_ADDR_WIDTH = 1,
    parameter int WORD_WIDTH      = 32,
    parameter int COUNT_WIDTH     = 16
);
    localparam int CW = $clog2(NUM_CHANNELS);

    logic                               cfg_valid;
    logic [CW-1:0]                      cfg_chan;
    logic [MAIN_ADDR_WIDTH-1:0]         cfg_base;
    logic [COUNT_WIDTH-1:0]             cfg_count;
    logic                               cfg_dir;

    logic [NUM_CHANNELS-1:0]            in_valid;
    logic [NUM_CHANNELS*WORD_WIDTH-1:0] in_value;
    logic [NUM_CHANNELS-1:0]            in_ready;

    logic                               out_valid;
    logic [CW-1:0]                      out_chan;
    logic [WORD_WIDTH-1:0]              out_value;
    logic                               out_ready;

    logic [NUM_CHANNELS-1:0]            chan_busy;
    logic [NUM_CHANNELS-1:0]            chan_done;

    logic                               mem_busy;
    logic                               stream_in;
    logic                               stream_out;
    logic [MAIN_ADDR_WIDTH-1:0]         stream_address;
    logic [WORD_WIDTH-1:0]              stream_in_value;
    logic [WORD_WIDTH-1:0]              read_value;

    modport master (
        input  cfg_valid, cfg_chan, cfg_base, cfg_count, cfg_dir,
        input  in_valid, in_value, out_ready, mem_busy, read_value,
        output in_ready, out_valid, out_chan, out_value, chan_busy, chan_done,
        output stream_in, stream_out, stream_address, stream_in_value
    );

    modport slave (
        output cfg_valid, cfg_chan, cfg_base, cfg_count, cfg_dir,
        output in_valid, in_value, out_ready, mem_busy, read_value,
        input  in_ready, out_valid, out_chan, out_value, chan_busy, chan_done,
        input  stream_in, stream_out, stream_address, stream_in_value
    );
endinterface

// File: rtl/stream_sched.sv
// Round-robin scheduler mapping DMA-style stream channels onto the single
// stream slot of the memory controller.
module stream_sched #(
    parameter int NUM_CHANNELS    = 4,
    parameter int MAIN_ADDR_WIDTH = 1,
    parameter int WORD_WIDTH      = 32,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic           clk,
    input  logic           reset,
    stream_sched_if.master bus
);
    localparam int CW = $clog2(NUM_CHANNELS);

    typedef enum logic { IDLE, ACTIVE } chan_state_t;

    chan_state_t                state [NUM_CHANNELS];
    logic                       dir   [NUM_CHANNELS];
    logic [MAIN_ADDR_WIDTH-1:0] addr  [NUM_CHANNELS];
    logic [COUNT_WIDTH-1:0]     count [NUM_CHANNELS];
    logic [CW-1:0]              rr;

    logic                    read_pending;
    logic                    pend_last;
    logic [CW-1:0]           pend_chan;
    logic                    out_full;
    logic                    out_last;
    logic [CW-1:0]           out_chan_q;
    logic [WORD_WIDTH-1:0]   out_value_q;
    logic [NUM_CHANNELS-1:0] done_q;
    logic [NUM_CHANNELS-1:0] done_next;
    logic [NUM_CHANNELS-1:0] eligible;

    logic          grant;
    logic [CW-1:0] win;
    logic          handshake;
    logic          final_word;
    logic          cfg_hits_win;

    assign handshake    = out_full && bus.out_ready;
    assign final_word   = (count[win] == COUNT_WIDTH'(1));
    assign cfg_hits_win = bus.cfg_valid && (bus.cfg_chan == win);

    // Out channels share one word slot, so any pending or held word blocks them all.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            eligible[c] = 1'b0;
            if (state[c] == ACTIVE) begin
                if (dir[c])
                    eligible[c] = bus.in_valid[c];
                else
                    eligible[c] = !out_full && !read_pending;
            end
        end
    end

    always_comb begin
        logic [CW-1:0] idx;
        grant = 1'b0;
        win   = rr;
        idx   = rr;
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            idx = rr + CW'(i);
            if (!grant && !bus.mem_busy && eligible[idx]) begin
                grant = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        bus.stream_in       = 1'b0;
        bus.stream_out      = 1'b0;
        bus.stream_address  = '0;
        bus.stream_in_value = '0;
        bus.in_ready        = '0;
        if (grant) begin
            bus.stream_address = addr[win];
            if (dir[win]) begin
                bus.stream_in       = 1'b1;
                bus.stream_in_value = bus.in_value[int'(win)*WORD_WIDTH +: WORD_WIDTH];
                bus.in_ready[win]   = 1'b1;
            end else begin
                bus.stream_out = 1'b1;
            end
        end
    end

    // A reconfiguration cancels the completion of the transfer it replaces.
    always_comb begin
        done_next = '0;
        if (grant && dir[win] && final_word)
            done_next[win] = 1'b1;
        if (bus.cfg_valid)
            done_next[bus.cfg_chan] = (bus.cfg_count == '0);
        if (handshake && out_last)
            done_next[out_chan_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c] <= IDLE;
                dir[c]   <= 1'b0;
                addr[c]  <= '0;
                count[c] <= '0;
            end
            rr           <= CW'(NUM_CHANNELS - 1);
            read_pending <= 1'b0;
            pend_last    <= 1'b0;
            pend_chan    <= '0;
            out_full     <= 1'b0;
            out_last     <= 1'b0;
            out_chan_q   <= '0;
            out_value_q  <= '0;
            done_q       <= '0;
        end else begin
            done_q <= done_next;
            if (grant) begin
                rr         <= win;
                addr[win]  <= addr[win] + MAIN_ADDR_WIDTH'(1);
                count[win] <= count[win] - COUNT_WIDTH'(1);
                if (final_word)
                    state[win] <= IDLE;
                if (!dir[win]) begin
                    read_pending <= 1'b1;
                    pend_chan    <= win;
                    pend_last    <= final_word && !cfg_hits_win;
                end
            end
            if (handshake)
                out_full <= 1'b0;
            if (read_pending) begin
                read_pending <= 1'b0;
                out_full     <= 1'b1;
                out_chan_q   <= pend_chan;
                out_value_q  <= bus.read_value;
                out_last     <= pend_last;
            end
            if (bus.cfg_valid) begin
                addr[bus.cfg_chan]  <= bus.cfg_base;
                count[bus.cfg_chan] <= bus.cfg_count;
                dir[bus.cfg_chan]   <= bus.cfg_dir;
                state[bus.cfg_chan] <= (bus.cfg_count != '0) ? ACTIVE : IDLE;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++)
            bus.chan_busy[c] = (state[c] == ACTIVE)
                            || (read_pending && pend_chan == CW'(c))
                            || (out_full && out_chan_q == CW'(c));
    end

    assign bus.out_valid = out_full;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_value = out_value_q;
    assign bus.chan_done = done_q;
endmodule
